// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory slice: access-size encodings,
// FSM states and the byte-enable helper.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } dm_state_e;

  // Reserved size yields no enabled lanes.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << lane;
      SZ_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_fmt.sv
// Combinational lane formatting: load extract/extend and store lane
// replication. Shared between data- and instruction-side memories.
module dm_lane_fmt
  import dm_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        uext_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ldata_o,
  output logic [31:0] wrep_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rword_i >> {lane_i, 3'b000};
    ldata_o = '0;
    wrep_o  = '0;
    case (size_i)
      SZ_BYTE: begin
        ldata_o = {{24{~uext_i & shifted[7]}}, shifted[7:0]};
        wrep_o  = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        ldata_o = {{16{~uext_i & shifted[15]}}, shifted[15:0]};
        wrep_o  = {2{wdata_i[15:0]}};
      end
      SZ_WORD: begin
        ldata_o = rword_i;
        wrep_o  = wdata_i;
      end
      default: begin
        ldata_o = '0;
        wrep_o  = '0;
      end
    endcase
  end

endmodule

// File: rtl/dm_pipe.sv
// Byte-addressed data memory with req/ready handshake and wait states.
// Optional DM_RANGE_CHECK_EN adds range_err for addresses >= DEPTH*4.
module dm_pipe
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wmem,
  input  logic [1:0]  size,
  input  logic        uext,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  output logic [31:0] dataout,
  output logic        ready,
  output logic        misalign,
  output logic        busy
`ifdef DM_RANGE_CHECK_EN
  ,
  output logic        range_err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  dm_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept;
  logic        wmem_q, uext_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;

  logic [31:0] mem [DEPTH];
  logic [AW-1:0] widx;
  logic [31:0] rword, ldata, wrep;
  logic [3:0]  be;
  logic        mis_c, rerr_c, we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wmem_q  <= 1'b0;
      uext_q  <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wmem_q  <= wmem;
        uext_q  <= uext;
        size_q  <= size;
        addr_q  <= addr;
        wdata_q <= datain;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (LATENCY > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign widx  = addr_q[AW+1:2];
  assign rword = mem[widx];
  assign be    = byte_en(size_q, addr_q[1:0]);

  assign mis_c = (size_q == SZ_HALF && addr_q[0]) ||
                 (size_q == SZ_WORD && addr_q[1:0] != 2'b00) ||
                 (size_q == 2'b11);

`ifdef DM_RANGE_CHECK_EN
  assign rerr_c    = |addr_q[31:AW+2];
  assign range_err = ready & rerr_c;
`else
  logic unused_addr_hi;
  assign rerr_c         = 1'b0;
  assign unused_addr_hi = ^addr_q[31:AW+2];
`endif

  dm_lane_fmt u_fmt (
    .size_i  (size_q),
    .lane_i  (addr_q[1:0]),
    .uext_i  (uext_q),
    .rword_i (rword),
    .wdata_i (wdata_q),
    .ldata_o (ldata),
    .wrep_o  (wrep)
  );

  assign ready    = (state_q == S_RESP);
  assign busy     = (state_q != S_IDLE);
  assign misalign = ready & mis_c;
  assign dataout  = (ready && !wmem_q && !mis_c && !rerr_c) ? ldata : '0;

  // A reset landing on the RESP edge must still abort the commit.
  assign we = ready && wmem_q && !mis_c && !rerr_c && !rst;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dm_pipe.sv
// Directed self-checking bench for dm_pipe (LATENCY=1 and LATENCY=0 instances).
module tb_dm_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req = 1'b0, wmem = 1'b0, uext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, datain = '0;
  logic [31:0] dataout;
  logic        ready, misalign, busy;

  logic        req0 = 1'b0, wmem0 = 1'b0, uext0 = 1'b0;
  logic [1:0]  size0 = 2'b00;
  logic [31:0] addr0 = '0, datain0 = '0;
  logic [31:0] dataout0;
  logic        ready0, misalign0, busy0;

`ifdef DM_RANGE_CHECK_EN
  logic        range_err, range_err0;
  logic        last_rerr;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dm_pipe #(.DEPTH(256), .LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .req(req), .wmem(wmem), .size(size), .uext(uext),
    .addr(addr), .datain(datain), .dataout(dataout), .ready(ready),
    .misalign(misalign), .busy(busy)
`ifdef DM_RANGE_CHECK_EN
    , .range_err(range_err)
`endif
  );

  dm_pipe #(.DEPTH(256), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .wmem(wmem0), .size(size0), .uext(uext0),
    .addr(addr0), .datain(datain0), .dataout(dataout0), .ready(ready0),
    .misalign(misalign0), .busy(busy0)
`ifdef DM_RANGE_CHECK_EN
    , .range_err(range_err0)
`endif
  );

  // One access on the LATENCY=1 instance; lat counts edges from acceptance to ready.
  task automatic acc(input logic w, input logic [1:0] sz, input logic ue,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic mis, output int lat);
    @(negedge clk);
    req = 1'b1; wmem = w; size = sz; uext = ue; addr = a; datain = d;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 1;
    while (!ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = dataout;
    mis = misalign;
`ifdef DM_RANGE_CHECK_EN
    last_rerr = range_err;
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (misalign !== 1'b0) begin fails++; $display("FAIL reset_misalign: got %b expected 0", misalign); end
    tests++; if (dataout !== 32'h0) begin fails++; $display("FAIL reset_dataout: got %h expected 00000000", dataout); end
    tests++; if (ready0 !== 1'b0) begin fails++; $display("FAIL reset_ready0: got %b expected 0", ready0); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic mis; int lat;
    acc(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, mis, lat);
    tests++; if (lat != 2) begin fails++; $display("FAIL word_store_latency: got %0d expected 2", lat); end
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL word_store_dataout: got %h expected 00000000", rd); end
    tests++; if (mis !== 1'b0) begin fails++; $display("FAIL word_store_misalign: got %b expected 0", mis); end
    acc(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, mis, lat);
    tests++; if (lat != 2) begin fails++; $display("FAIL word_load_latency: got %0d expected 2", lat); end
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL word_load_data: got %h expected deadbeef", rd); end
    tests++; if (mis !== 1'b0) begin fails++; $display("FAIL word_load_misalign: got %b expected 0", mis); end
  endtask

  task automatic test_byte_half();
    logic [31:0] rd; logic mis; int lat;
    acc(1'b1, 2'b00, 1'b0, 32'h13, 32'hAAAAAA80, rd, mis, lat);
    acc(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, mis, lat);
    tests++; if (rd !== 32'hFFFFFF80) begin fails++; $display("FAIL byte_load_sext: got %h expected ffffff80", rd); end
    acc(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, mis, lat);
    tests++; if (rd !== 32'h00000080) begin fails++; $display("FAIL byte_load_zext: got %h expected 00000080", rd); end
    acc(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, mis, lat);
    tests++; if (rd !== 32'h80ADBEEF) begin fails++; $display("FAIL byte_merge_word: got %h expected 80adbeef", rd); end
    acc(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rd, mis, lat);
    tests++; if (rd !== 32'hFFFF80AD) begin fails++; $display("FAIL half_load_sext: got %h expected ffff80ad", rd); end
    acc(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, rd, mis, lat);
    tests++; if (rd !== 32'h0000BEEF) begin fails++; $display("FAIL half_load_zext: got %h expected 0000beef", rd); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic mis; int lat;
    acc(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, rd, mis, lat);
    tests++; if (mis !== 1'b1) begin fails++; $display("FAIL mis_half_flag: got %b expected 1", mis); end
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL mis_half_data: got %h expected 00000000", rd); end
    acc(1'b1, 2'b10, 1'b0, 32'h12, 32'h11111111, rd, mis, lat);
    tests++; if (mis !== 1'b1) begin fails++; $display("FAIL mis_word_flag: got %b expected 1", mis); end
    acc(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd, mis, lat);
    tests++; if (mis !== 1'b1) begin fails++; $display("FAIL mis_rsvd_flag: got %b expected 1", mis); end
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL mis_rsvd_data: got %h expected 00000000", rd); end
    acc(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, mis, lat);
    tests++; if (rd !== 32'h80ADBEEF) begin fails++; $display("FAIL mis_no_write: got %h expected 80adbeef", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic mis; int lat;
    acc(1'b1, 2'b10, 1'b0, 32'h004, 32'hCAFEF00D, rd, mis, lat);
    acc(1'b1, 2'b10, 1'b0, 32'h404, 32'h12345678, rd, mis, lat);
`ifdef DM_RANGE_CHECK_EN
    tests++; if (last_rerr !== 1'b1) begin fails++; $display("FAIL range_err_flag: got %b expected 1", last_rerr); end
    tests++; if (lat != 2) begin fails++; $display("FAIL range_latency: got %0d expected 2", lat); end
    acc(1'b0, 2'b10, 1'b0, 32'h004, 32'h0, rd, mis, lat);
    tests++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL range_no_write: got %h expected cafef00d", rd); end
    tests++; if (last_rerr !== 1'b0) begin fails++; $display("FAIL range_err_inrange: got %b expected 0", last_rerr); end
`else
    acc(1'b0, 2'b10, 1'b0, 32'h004, 32'h0, rd, mis, lat);
    tests++; if (rd !== 32'h12345678) begin fails++; $display("FAIL wrap_load: got %h expected 12345678", rd); end
`endif
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic mis; int lat; int pulses;
    acc(1'b1, 2'b10, 1'b0, 32'h20, 32'h01020304, rd, mis, lat);
    @(negedge clk);
    req = 1'b1; wmem = 1'b1; size = 2'b10; addr = 32'h20; datain = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy_wait: got %b expected 1", busy); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy_after_rst: got %b expected 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
    tests++; if (pulses != 0) begin fails++; $display("FAIL abort_no_ready: got %0d pulses expected 0", pulses); end
    acc(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, mis, lat);
    tests++; if (rd !== 32'h01020304) begin fails++; $display("FAIL abort_no_write: got %h expected 01020304", rd); end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  pat;
    logic [31:0] rd_a, rd_b;
    @(negedge clk);
    req0 = 1'b1; wmem0 = 1'b1; size0 = 2'b10; uext0 = 1'b0;
    addr0 = 32'h8; datain0 = 32'h11223344;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      pat[6-i] = ready0;
      if (i == 0) begin addr0 = 32'hC; datain0 = 32'h55667788; end
      if (i == 2) begin wmem0 = 1'b0; addr0 = 32'h8; datain0 = 32'h0; end
      if (i == 4) begin rd_a = dataout0; addr0 = 32'hC; end
      if (i == 6) rd_b = dataout0;
    end
    req0 = 1'b0;
    tests++; if (pat !== 7'b1010101) begin fails++; $display("FAIL b2b_ready_pattern: got %b expected 1010101", pat); end
    tests++; if (rd_a !== 32'h11223344) begin fails++; $display("FAIL b2b_load_first: got %h expected 11223344", rd_a); end
    tests++; if (rd_b !== 32'h55667788) begin fails++; $display("FAIL b2b_load_second: got %h expected 55667788", rd_b); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_misalign();
    test_wrap();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
